// File: rtl/ztex_bridge_pkg.sv
// ztex_bridge_pkg: shared constants for the host bridge (output frame length, status byte layout, core id width)
package ztex_bridge_pkg;
  localparam int CORE_ID_W = 8;
  localparam int ST_VALID = 7;
  localparam int ST_OVF = 6;
  localparam int ST_CNT_W = 6;
  function automatic int out_bytes(input int res_bytes);
    return res_bytes + 2;
  endfunction
endpackage

// File: rtl/ztex_strobe_sync.sv
// ztex_strobe_sync: 4-flop synchroniser for an async host strobe; emits one pulse per filtered level change
module ztex_strobe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  output logic strobe,
  output logic rise
);
  logic [3:0] s;
  logic lvl;
  // s[0] absorbs metastability; a new level must fill s[3:1] before it is accepted against lvl
  assign strobe = s[3] == s[2] && s[2] == s[1] && s[1] != lvl;
  assign rise = strobe & s[1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s <= '0;
      lvl <= 1'b0;
    end else begin
      s <= {s[2:0], a};
      if (strobe) lvl <= s[1];
    end
endmodule

// File: rtl/ztex_host_bridge.sv
// ztex_host_bridge: EZ-USB byte-port bridge feeding work frames to NUM_CORES miners and returning results.
// ZTEX_BRIDGE_CHECKSUM_EN adds a trailing XOR byte per work frame and reports checksum errors in byte0.
module ztex_host_bridge
  import ztex_bridge_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int IN_BYTES   = 44,
  parameter int RES_BYTES  = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             rd_clk,
  input  logic                             wr_clk,
  input  logic                             wr_start,
  input  logic [7:0]                       read,
  output logic [7:0]                       write,
  output logic [IN_BYTES*8-1:0]            work_data,
  output logic                             work_valid,
  input  logic [NUM_CORES-1:0]             res_valid,
  input  logic [NUM_CORES*RES_BYTES*8-1:0] res_data
);
  localparam int IW = IN_BYTES * 8;
  localparam int RB = RES_BYTES * 8;
  localparam int EW = RB + CORE_ID_W;
  localparam int OW = out_bytes(RES_BYTES) * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
`ifdef ZTEX_BRIDGE_CHECKSUM_EN
  localparam int FB = IN_BYTES + 1;
`else
  localparam int FB = IN_BYTES;
`endif
  localparam int CW = $clog2(FB + 1);

  logic rd_stb, rd_rise, wr_stb, wr_rise, ws_stb, ws_rise;
  logic unused;
  assign unused = ^{rd_rise, wr_rise, ws_stb};

  ztex_strobe_sync u_rd (.clk(clk), .reset_n(reset_n), .a(rd_clk), .strobe(rd_stb), .rise(rd_rise));
  ztex_strobe_sync u_wr (.clk(clk), .reset_n(reset_n), .a(wr_clk), .strobe(wr_stb), .rise(wr_rise));
  ztex_strobe_sync u_ws (.clk(clk), .reset_n(reset_n), .a(wr_start), .strobe(ws_stb), .rise(ws_rise));

  logic [7:0] read_q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] shreg;
  logic [ST_CNT_W-1:0] st_low;
  logic [AW:0] count;

`ifdef ZTEX_BRIDGE_CHECKSUM_EN
  logic [7:0] csum, err;
  assign st_low = err[ST_CNT_W-1:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      read_q <= '0;
      cnt <= '0;
      shreg <= '0;
      work_data <= '0;
      work_valid <= 1'b0;
      csum <= '0;
      err <= '0;
    end else begin
      read_q <= read;
      work_valid <= 1'b0;
      if (ws_rise) begin
        cnt <= '0;
        csum <= '0;
      end else if (rd_stb) begin
        if (cnt == CW'(IN_BYTES)) begin
          cnt <= '0;
          csum <= '0;
          if (read_q == csum) begin
            work_data <= shreg;
            work_valid <= 1'b1;
          end else if (err != 8'hff) err <= err + 8'd1;
        end else begin
          shreg <= {read_q, shreg[IW-1:8]};
          csum <= csum ^ read_q;
          cnt <= cnt + CW'(1);
        end
      end
    end
`else
  assign st_low = ST_CNT_W'(count);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      read_q <= '0;
      cnt <= '0;
      shreg <= '0;
      work_data <= '0;
      work_valid <= 1'b0;
    end else begin
      read_q <= read;
      work_valid <= 1'b0;
      if (ws_rise) cnt <= '0;
      else if (rd_stb) begin
        shreg <= {read_q, shreg[IW-1:8]};
        if (cnt == CW'(IN_BYTES - 1)) begin
          cnt <= '0;
          work_data <= {read_q, shreg[IW-1:8]};
          work_valid <= 1'b1;
        end else cnt <= cnt + CW'(1);
      end
    end
`endif

  logic [NUM_CORES-1:0] pend, gsel;
  logic [RB-1:0] pdata [NUM_CORES];
  logic [PW-1:0] ptr, gidx;
  logic gnt, cap_ovf;

  // lowest offset from ptr wins, so the loop runs downwards and the last hit is kept
  always_comb begin
    gnt = 1'b0;
    gidx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (pend[(int'(ptr) + k) % NUM_CORES]) begin
        gnt = 1'b1;
        gidx = PW'((int'(ptr) + k) % NUM_CORES);
      end
  end

  assign gsel = NUM_CORES'(gnt) << gidx;
  assign cap_ovf = |(res_valid & pend & ~gsel);

  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CORES; i++)
      if (res_valid[i]) pdata[i] <= res_data[i*RB +: RB];

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] frame;
  logic [7:0] status;
  logic full, pop, push, ovf, ovf_set;

  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = ws_rise && count != '0;
  assign push = gnt && (!full || pop);
  assign ovf_set = cap_ovf | (gnt & full & ~pop);
  assign status = {count != '0, ovf, st_low};

  always_ff @(posedge clk)
    if (push) mem[wp] <= {CORE_ID_W'(gidx), pdata[gidx]};

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend <= '0;
      ptr <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
      frame <= '0;
      write <= '0;
    end else begin
      pend <= (pend & ~gsel) | res_valid;
      if (gnt) ptr <= int'(gidx) == NUM_CORES - 1 ? '0 : gidx + PW'(1);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      // a loss in the same cycle as the report must survive into the next frame
      ovf <= ws_rise ? ovf_set : ovf | ovf_set;
      if (ws_rise) frame <= pop ? {mem[rp], status} : {(OW-8)'(0), status};
      else if (wr_stb) frame <= {8'h00, frame[OW-1:8]};
      write <= frame[7:0];
    end
endmodule
